// File: rtl/regfile_nrd.sv
// LEGv8 register file: 2^A x N storage, one write port, NUM_RD read ports.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching reads.
module regfile_nrd #(
  parameter int N        = 64,
  parameter int A        = 5,
  parameter int NUM_RD   = 2,
  parameter int READ_REG = 0,
  parameter int ZERO_EN  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [A-1:0]        wa,
  input  logic [N-1:0]        wd,
  input  logic [NUM_RD*A-1:0] ra,
  output logic [NUM_RD*N-1:0] rd
);

  localparam int          DEPTH = 2 ** A;
  localparam logic [A-1:0] ZA   = '1;

  logic [N-1:0] r [DEPTH];
  logic         wa_zero;
  logic         wr_ok;

  assign wa_zero = (ZERO_EN != 0) && (wa == ZA);
  assign wr_ok   = we && !wa_zero;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r[i] <= '0;
      end
    end else if (wr_ok) begin
      r[wa] <= wd;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [A-1:0] a;
    logic [N-1:0] v;

    assign a = ra[k*A +: A];

    // zero register wins over any forwarded write
    always_comb begin
      v = r[a];
`ifdef REGFILE_BYPASS_EN
      if (we && (wa == a)) begin
        v = wd;
      end
`endif
      if ((ZERO_EN != 0) && (a == ZA)) begin
        v = '0;
      end
    end

    if (READ_REG != 0) begin : g_reg
      logic [N-1:0] q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          q <= '0;
        end else begin
          q <= v;
        end
      end

      assign rd[k*N +: N] = q;
    end else begin : g_comb
      assign rd[k*N +: N] = v;
    end
  end

endmodule

// File: tb/tb_regfile_nrd.sv
// Bench for regfile_nrd: a combinational 4-port zero-reg instance and a
// registered 2-port instance without zero reg, checked against a model.
module tb_regfile_nrd;

  logic         clk;
  logic         rst_n;
  logic         we;
  logic [4:0]   wa;
  logic [63:0]  wd;
  logic [19:0]  ra0;
  logic [9:0]   ra1;
  logic [255:0] rd0;
  logic [127:0] rd1;

  int checks;
  int failures;
  bit armed;

  logic [63:0] mem0 [32];
  logic [63:0] mem1 [32];
  logic [63:0] exp1 [2];

  assign ra1 = ra0[9:0];

  regfile_nrd #(
    .N(64), .A(5), .NUM_RD(4), .READ_REG(0), .ZERO_EN(1)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .ra(ra0), .rd(rd0)
  );

  regfile_nrd #(
    .N(64), .A(5), .NUM_RD(2), .READ_REG(1), .ZERO_EN(0)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .ra(ra1), .rd(rd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  function automatic logic [63:0] m0(input logic [4:0] a);
    if (a == 5'd31) return 64'd0;
    if (BYP && we && wa == a) return wd;
    return mem0[a];
  endfunction

  function automatic logic [63:0] m1(input logic [4:0] a);
    if (BYP && we && wa == a) return wd;
    return mem1[a];
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        mem0[i] <= 64'd0;
        mem1[i] <= 64'd0;
      end
      exp1[0] <= 64'd0;
      exp1[1] <= 64'd0;
    end else begin
      exp1[0] <= m1(ra0[4:0]);
      exp1[1] <= m1(ra0[9:5]);
      if (we) begin
        if (wa != 5'd31) mem0[wa] <= wd;
        mem1[wa] <= wd;
      end
    end
  end

  task automatic compare_all();
    logic [63:0] g;
    logic [63:0] e;
    for (int k = 0; k < 4; k++) begin
      g = rd0[k*64 +: 64];
      e = m0(ra0[k*5 +: 5]);
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL comb_port%0d t=%0t got=%h want=%h", k, $time, g, e);
      end
    end
    for (int k = 0; k < 2; k++) begin
      g = rd1[k*64 +: 64];
      e = exp1[k];
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL reg_port%0d t=%0t got=%h want=%h", k, $time, g, e);
      end
    end
  endtask

  task automatic cycle();
    #2;
    if (armed) compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic lit(input string name, input logic [255:0] got,
                     input logic [255:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic setra(input logic [4:0] a0, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [4:0] a3);
    ra0 = {a3, a2, a1, a0};
  endtask

  task automatic wr(input logic [4:0] a, input logic [63:0] d);
    we = 1'b1;
    wa = a;
    wd = d;
    cycle();
    we = 1'b0;
  endtask

  localparam logic [63:0] V5   = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] ONES = '1;

  initial begin
    checks   = 0;
    failures = 0;
    armed    = 1'b0;
    rst_n    = 1'b0;
    we       = 1'b1;
    wa       = 5'd3;
    wd       = 64'hAA;
    setra(3, 3, 3, 3);
    cycle();
    armed = 1'b1;
    cycle();
    rst_n = 1'b1;
    we    = 1'b0;

    for (int i = 0; i < 32; i++) begin
      setra(5'(i), 5'(i), 5'(i), 5'(i));
      cycle();
    end
    setra(3, 3, 3, 3);
    settle();
    lit("reset_r3_comb", 256'(rd0), 256'd0);
    lit("reset_r3_reg", 256'(rd1), 256'd0);

    setra(0, 0, 0, 0);
    wr(5, V5);
    setra(5, 5, 5, 5);
    settle();
    lit("x5_comb", 256'(rd0[63:0]), 256'(V5));
    cycle();
    lit("x5_reg", 256'(rd1), 256'({V5, V5}));

    we = 1'b1;
    wa = 5'd31;
    wd = ONES;
    setra(31, 31, 31, 31);
    settle();
    lit("xzr_write_cycle", 256'(rd0), 256'd0);
    cycle();
    we = 1'b0;
    cycle();
    lit("xzr_comb", 256'(rd0), 256'd0);
    lit("x31_plain_reg", 256'(rd1[63:0]), 256'(ONES));

    setra(0, 0, 0, 0);
    wr(7, 64'h10);
    we = 1'b1;
    wa = 5'd7;
    wd = 64'h20;
    setra(7, 7, 7, 7);
    settle();
    lit("hazard_same", 256'(rd0[63:0]), BYP ? 256'h20 : 256'h10);
    cycle();
    we = 1'b0;
    settle();
    lit("hazard_next", 256'(rd0[63:0]), 256'h20);
    lit("hazard_reg", 256'(rd1[63:0]), BYP ? 256'h20 : 256'h10);
    cycle();
    lit("hazard_reg_next", 256'(rd1[63:0]), 256'h20);

    for (int i = 1; i <= 4; i++) wr(5'(i), 64'(i));
    setra(1, 2, 3, 4);
    settle();
    lit("multi_comb", rd0, {64'd4, 64'd3, 64'd2, 64'd1});
    cycle();
    lit("multi_reg", 256'(rd1), 256'({64'd2, 64'd1}));
    for (int i = 0; i < 8; i++) begin
      setra(5'((i % 4) + 1), 5'(((i + 1) % 4) + 1),
            5'(((i + 2) % 4) + 1), 5'(((i + 3) % 4) + 1));
      cycle();
    end
    setra(4, 3, 2, 1);
    settle();
    lit("multi_swap", rd0, {64'd1, 64'd2, 64'd3, 64'd4});

    for (int i = 0; i < 50; i++) begin
      we = 1'($urandom_range(0, 1));
      wa = 5'($urandom_range(0, 31));
      wd = {$urandom, $urandom};
      ra0 = 20'($urandom);
      cycle();
    end
    rst_n = 1'b0;
    we    = 1'b1;
    wa    = 5'd9;
    wd    = 64'hDEAD;
    setra(9, 9, 9, 9);
    cycle();
    rst_n = 1'b1;
    we    = 1'b0;
    settle();
    lit("midrst_x9_comb", rd0, 256'd0);
    lit("midrst_reg", 256'(rd1), 256'd0);
    for (int i = 0; i < 32; i++) begin
      setra(5'(i), 5'(i), 5'(31 - i), 5'(31 - i));
      cycle();
    end
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
